// File: rtl/csa_accumulator.sv
// csa_accumulator
// ---------------------------------------------------------------------------
// Carry-save accumulator feeding a downstream N-bit carry-propagate adder.
// Each accepted signed term is folded into a sum/carry vector pair with one
// 3:2 compressor per bit, so no carry propagates inside this block. The
// downstream CPA resolves out_sum + out_carry into the two's-complement result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      job start pulse, sampled only in IDLE
//   len        number of terms in the job, sampled with start
//   in_valid   in_data carries a term this cycle
//   in_ready   block accepts a term this cycle (ACCUM only)
//   in_data    signed term, IN_W bits
//   out_valid  out_sum/out_carry hold a finished result (DONE only)
//   out_ready  downstream consumes the result
//   out_sum    redundant sum vector (CPA operand a)
//   out_carry  redundant carry vector (CPA operand b)
//   busy       high in any state other than IDLE
//   dbg_state  registered FSM state, for observation only
//
// Handshake: a transfer happens at a rising edge where valid && ready are
// both high. Ready/valid outputs are decoded from registered state only, so
// in_ready never depends on in_valid and out_valid never depends on out_ready.
// ---------------------------------------------------------------------------
module csa_accumulator #(
  parameter int N     = 40,
  parameter int IN_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [N-1:0]     out_carry,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     s_q, s_d;
  logic [N-1:0]     c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0] x_ext;
  logic [N-1:0] maj;
  logic         accept;

  // Sign-extend the incoming term to the accumulator width.
  assign x_ext = N'($signed(in_data));

  // Per-bit 3:2 compression; carries shift up one place and the carry out of
  // the top bit falls off, which gives modulo 2^N wrap.
  assign maj = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = s_q;
  assign out_carry = c_q;
  assign dbg_state = state_q;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d = '0;
          c_d = '0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          s_d   = s_q ^ c_q ^ x_ext;
          c_d   = {maj[N-2:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Vectors held; they also stay put after the return to IDLE.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
